// File: rtl/lu_arbiter.sv
// lu_arbiter: shares one LogicUnit (one-cycle registered latency) between NREQ issue slots.
// Define LU_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise the lowest requesting index wins.
module lu_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 32,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [2:0]        lu_op,
    output logic [W-1:0]      lu_a,
    output logic [W-1:0]      lu_b,
    input  logic [W-1:0]      lu_result,
    output logic              resp_valid,
    output logic [IDW-1:0]    resp_id,
    output logic [W-1:0]      resp_data,
    input  logic              resp_ready
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic           accept;
    logic [IDW-1:0] grant;

    assign accept = (|req_valid) && ((state_q == IDLE) || ((state_q == RESP) && resp_ready));

`ifdef LU_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] last_q;

    // Search starts one past the last grant and wraps modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(last_q) + k) % NREQ;
            if (!found && req_valid[IDW'(idx)]) begin
                grant = IDW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDW'(NREQ - 1);
        end else if (accept) begin
            last_q <= grant;
        end
    end
`else
    always_comb begin
        logic found;
        found = 1'b0;
        grant = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[IDW'(k)]) begin
                grant = IDW'(k);
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_ready) state_d = accept ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
        resp_valid = (state_q == RESP);
    end

    // Held from accept to the next accept so a stalled RESP keeps lu_result stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_op   <= '0;
            lu_a    <= '0;
            lu_b    <= '0;
            resp_id <= '0;
        end else if (accept) begin
            lu_op   <= req_op[3*grant +: 3];
            lu_a    <= req_a[W*grant +: W];
            lu_b    <= req_b[W*grant +: W];
            resp_id <= grant;
        end
    end

    assign resp_data = lu_result;

endmodule

// File: tb/tb_lu_arbiter.sv
// Directed self-checking bench for lu_arbiter with a behavioural LogicUnit (registered, 1-cycle).
module tb_lu_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 32;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [2:0]        lu_op;
    logic [W-1:0]      lu_a;
    logic [W-1:0]      lu_b;
    logic [W-1:0]      lu_result;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [W-1:0]      resp_data;
    logic              resp_ready;

    int unsigned passed = 0;
    int unsigned fails  = 0;
    int unsigned total  = 0;
    int unsigned g;

    logic [2:0]  ops  [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
    logic [31:0] exps [7] = '{32'h0000_0000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF,
                              32'hFFFF_00F0, 32'hFFFF_0000, 32'hFFFF_0000};

    always #5 clk = ~clk;

    lu_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .lu_op      (lu_op),
        .lu_a       (lu_a),
        .lu_b       (lu_b),
        .lu_result  (lu_result),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always_ff @(posedge clk) begin
        case (lu_op)
            3'b000:  lu_result <= lu_a & lu_b;
            3'b001:  lu_result <= lu_a ^ lu_b;
            3'b010:  lu_result <= ~(lu_a & lu_b);
            3'b011:  lu_result <= lu_a | lu_b;
            3'b100:  lu_result <= ~lu_a;
            3'b101:  lu_result <= ~(lu_a | lu_b);
            3'b110:  lu_result <= lu_a << lu_b[4:0];
            default: lu_result <= ~(lu_a ^ lu_b);
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*s +: 3] = op;
        req_a[W*s +: W]  = a;
        req_b[W*s +: W]  = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_lu_op", 32'(lu_op), 32'd0);
        chk("rst_lu_a", lu_a, 32'd0);
        chk("rst_lu_b", lu_b, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        step();
        rst_n = 1'b1;

        // Single request on slot 2
        set_slot(2, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        req_valid = 4'b0100; resp_ready = 1'b1;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h4);
        step();
        chk("single_exec_valid", 32'(resp_valid), 32'd0);
        chk("single_exec_req_ready", 32'(req_ready), 32'd0);
        chk("single_lu_op", 32'(lu_op), 32'd0);
        chk("single_lu_a", lu_a, 32'hF0F0_F0F0);
        chk("single_lu_b", lu_b, 32'hFF00_FF00);
        req_valid = '0;
        step();
        chk("single_resp_valid", 32'(resp_valid), 32'd1);
        chk("single_resp_id", 32'(resp_id), 32'd2);
        chk("single_resp_data", resp_data, 32'hF000_F000);
        step();
        chk("single_back_idle", 32'(resp_valid), 32'd0);

        // Contention from a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) set_slot(s, 3'b011, 32'h100, 32'(s));
        req_valid = 4'b1111; resp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
`ifdef LU_ARB_ROUND_ROBIN_EN
            g = n % 4;
`else
            g = 0;
`endif
            chk($sformatf("cont%0d_req_ready", n), 32'(req_ready), 32'(1) << g);
            step();
            chk($sformatf("cont%0d_exec_req_ready", n), 32'(req_ready), 32'd0);
            chk($sformatf("cont%0d_lu_b", n), lu_b, g);
            step();
            chk($sformatf("cont%0d_resp_valid", n), 32'(resp_valid), 32'd1);
            chk($sformatf("cont%0d_resp_id", n), 32'(resp_id), g);
            chk($sformatf("cont%0d_resp_data", n), resp_data, 32'h100 | g);
        end
        req_valid = '0;
        step();
        chk("cont_back_idle", 32'(resp_valid), 32'd0);

        // Backpressure on slot 0 while slot 1 waits, then overlapped accept
        set_slot(0, 3'b111, 32'h1234_5678, 32'h1234_5678);
        req_valid = 4'b0001; resp_ready = 1'b0;
        #1;
        chk("bp_req_ready", 32'(req_ready), 32'h1);
        step();
        set_slot(1, 3'b100, 32'h0, 32'hDEAD_BEEF);
        req_valid = 4'b0010;
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd1);
            chk($sformatf("bp%0d_resp_data", k), resp_data, 32'hFFFF_FFFF);
            chk($sformatf("bp%0d_resp_id", k), 32'(resp_id), 32'd0);
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_lu_a", k), lu_a, 32'h1234_5678);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("ovl_resp_valid", 32'(resp_valid), 32'd1);
        chk("ovl_resp_data", resp_data, 32'hFFFF_FFFF);
        chk("ovl_req_ready", 32'(req_ready), 32'h2);
        step();
        chk("ovl_exec_valid", 32'(resp_valid), 32'd0);
        chk("ovl_lu_op", 32'(lu_op), 32'h4);
        chk("ovl_lu_a", lu_a, 32'h0);
        chk("ovl_lu_b", lu_b, 32'hDEAD_BEEF);
        req_valid = '0;
        step();
        chk("ovl_resp_valid2", 32'(resp_valid), 32'd1);
        chk("ovl_resp_id", 32'(resp_id), 32'd1);
        chk("ovl_resp_data2", resp_data, 32'hFFFF_FFFF);
        step();

        // Reset while in EXEC
        set_slot(1, 3'b011, 32'h1, 32'h2);
        req_valid = 4'b0010;
        #1;
        chk("rx_req_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        chk("rx_exec_lu_a", lu_a, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rx_resp_valid", 32'(resp_valid), 32'd0);
        chk("rx_lu_op", 32'(lu_op), 32'd0);
        chk("rx_lu_a", lu_a, 32'd0);
        chk("rx_lu_b", lu_b, 32'd0);
        chk("rx_resp_id", 32'(resp_id), 32'd0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("rx%0d_no_resp", k), 32'(resp_valid), 32'd0);
        end
        set_slot(0, 3'b001, 32'hA5, 32'h0F);
        set_slot(2, 3'b000, 32'h0, 32'h0);
        req_valid = 4'b0101;
        #1;
        chk("rx_next_grant", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        step();
        chk("rx_next_resp_id", 32'(resp_id), 32'd0);
        chk("rx_next_resp_data", resp_data, 32'hAA);
        step();

        // Opcode sweep on slot 3
        for (int i = 0; i < 7; i++) begin
            set_slot(3, ops[i], 32'h0000_FF0F, 32'h0000_00F0);
            req_valid = 4'b1000;
            #1;
            chk($sformatf("op%0d_req_ready", ops[i]), 32'(req_ready), 32'h8);
            step();
            req_valid = '0;
            step();
            chk($sformatf("op%0d_resp_id", ops[i]), 32'(resp_id), 32'd3);
            chk($sformatf("op%0d_resp_data", ops[i]), resp_data, exps[i]);
        end
        step();
        chk("sweep_back_idle", 32'(resp_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
